mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit.sv | 133 +++++++++++++
 tb/tb_mult_div_unit.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit holding the HI/LO register pair.
// Define MDU_MADD_MSUB_EN to enable the multiply-accumulate ops (Op 6 MADD, Op 7 MSUB).
module mult_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [2:0]  Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
`ifdef MDU_MADD_MSUB_EN
  localparam logic [2:0] OP_MADD  = 3'd6;
  localparam logic [2:0] OP_MSUB  = 3'd7;
`endif

  // Declaration initialisers give the all-zero power-up state before the first reset.
  logic [1:0]  state  = ST_IDLE;
  logic [3:0]  cnt    = 4'd0;
  logic        busy_q = 1'b0;
  logic [31:0] hi_q   = 32'd0;
  logic [31:0] lo_q   = 32'd0;
  logic [2:0]  op_q   = 3'd0;
  logic [31:0] a_q    = 32'd0;
  logic [31:0] b_q    = 32'd0;

  logic [63:0] prod_s, prod_u, mul_res;
  logic        neg_a, neg_b;
  logic [31:0] abs_a, abs_b, q_mag, r_mag, div_q, div_r;

  // Signed product as the low 64 bits of a sign-extended 64x64 multiply.
  always_comb begin
    prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    prod_u = {32'd0, a_q} * {32'd0, b_q};
    mul_res = prod_u;
    case (op_q)
      OP_MULT:  mul_res = prod_s;
`ifdef MDU_MADD_MSUB_EN
      OP_MADD:  mul_res = {hi_q, lo_q} + prod_s;
      OP_MSUB:  mul_res = {hi_q, lo_q} - prod_s;
`endif
      default:  mul_res = prod_u;
    endcase
  end

  // Divide on magnitudes so 0x80000000 / -1 wraps cleanly instead of overflowing.
  always_comb begin
    neg_a = (op_q == OP_DIV) && a_q[31];
    neg_b = (op_q == OP_DIV) && b_q[31];
    abs_a = neg_a ? (32'd0 - a_q) : a_q;
    abs_b = neg_b ? (32'd0 - b_q) : b_q;
    q_mag = (abs_b != 32'd0) ? (abs_a / abs_b) : 32'd0;
    r_mag = (abs_b != 32'd0) ? (abs_a % abs_b) : 32'd0;
    div_q = (neg_a ^ neg_b) ? (32'd0 - q_mag) : q_mag;
    div_r = neg_a ? (32'd0 - r_mag) : r_mag;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      cnt    <= 4'd0;
      busy_q <= 1'b0;
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (Start) begin
            case (Op)
              OP_MULT, OP_MULTU,
`ifdef MDU_MADD_MSUB_EN
              OP_MADD, OP_MSUB,
`endif
              OP_DIV, OP_DIVU: begin
                op_q   <= Op;
                a_q    <= A;
                b_q    <= B;
                busy_q <= 1'b1;
                if (Op == OP_DIV || Op == OP_DIVU) begin
                  cnt   <= 4'd10;
                  state <= ST_DIV;
                end else begin
                  cnt   <= 4'd5;
                  state <= ST_MUL;
                end
              end
              OP_MTHI: hi_q <= A;
              OP_MTLO: lo_q <= A;
              default: ;
            endcase
          end
        end
        ST_MUL, ST_DIV: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
            if (state == ST_MUL) begin
              {hi_q, lo_q} <= mul_res;
            end else if (b_q != 32'd0) begin
              {hi_q, lo_q} <= {div_r, div_q};
            end
          end
        end
        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: operand/op latches carry no reset; they are only read after Start reloads them.

  assign Busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: vector table plus scoreboard, then corner sequences.
module tb_mult_div_unit;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        Start = 1'b0;
  logic [2:0]  Op    = 3'd0;
  logic [31:0] A     = 32'd0;
  logic [31:0] B     = 32'd0;
  logic        Busy;
  logic [31:0] HI, LO;

  int total = 0;
  int bad   = 0;

  mult_div_unit dut (
    .clk  (clk),
    .reset(reset),
    .Start(Start),
    .Op   (Op),
    .A    (A),
    .B    (B),
    .Busy (Busy),
    .HI   (HI),
    .LO   (LO)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; drives Start for one edge, then scrambles operands while busy.
  task automatic issue(input string name, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                       input int ecyc);
    exp_t e;
    e.name = name;
    e.hi   = ehi;
    e.lo   = elo;
    e.cyc  = ecyc;
    sb.push_back(e);
    Start = 1'b1;
    Op    = op;
    A     = a;
    B     = b;
    @(negedge clk);
    Start = 1'b0;
    A     = $urandom;
    B     = $urandom;
  endtask

  // Counts busy cycles (bounded), then compares against the oldest scoreboard entry.
  task automatic finish_op();
    int   cyc = 0;
    exp_t e;
    while (Busy === 1'b1 && cyc < 40) begin
      cyc++;
      @(negedge clk);
    end
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard: empty on completion, got busy=%0d, expected an entry", cyc);
    end else begin
      e = sb.pop_front();
      check({e.name, " busy_cycles"}, 32'(cyc), 32'(e.cyc));
      check({e.name, " HI"}, HI, e.hi);
      check({e.name, " LO"}, LO, e.lo);
    end
  endtask

  initial begin
    tbl[0]  = '{3'd0, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5};
    tbl[1]  = '{3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    tbl[2]  = '{3'd3, 32'd7,        32'd0,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    tbl[3]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
    tbl[4]  = '{3'd3, 32'd100,      32'd7,        32'd2,        32'd14,       10};
    tbl[5]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
    tbl[6]  = '{3'd2, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 10};
    tbl[7]  = '{3'd4, 32'h12345678, 32'd0,        32'h12345678, 32'hFFFFFFFD, 0};
    tbl[8]  = '{3'd5, 32'hFFFFFFFF, 32'd0,        32'h12345678, 32'hFFFFFFFF, 0};
    tbl[9]  = '{3'd4, 32'd0,        32'd0,        32'h00000000, 32'hFFFFFFFF, 0};
`ifdef MDU_MADD_MSUB_EN
    tbl[10] = '{3'd6, 32'd1,        32'd1,        32'h00000001, 32'h00000000, 5};
    tbl[11] = '{3'd7, 32'd2,        32'd3,        32'h00000000, 32'hFFFFFFFA, 5};
`else
    tbl[10] = '{3'd6, 32'd1,        32'd1,        32'h00000000, 32'hFFFFFFFF, 0};
    tbl[11] = '{3'd7, 32'd2,        32'd3,        32'h00000000, 32'hFFFFFFFF, 0};
`endif
    tbl[12] = '{3'd0, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000, 5};
    tbl[13] = '{3'd1, 32'h80000000, 32'd2,        32'h00000001, 32'h00000000, 5};

    #1;
    check("t0 Busy", {31'd0, Busy}, 32'd0);
    check("t0 HI", HI, 32'd0);
    check("t0 LO", LO, 32'd0);

    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("reset Busy", {31'd0, Busy}, 32'd0);
    check("reset HI", HI, 32'd0);
    check("reset LO", LO, 32'd0);

    // Back-to-back table ops: each Start lands on the first Busy=0 cycle.
    for (int i = 0; i < 14; i++) begin
      issue($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b,
            tbl[i].hi, tbl[i].lo, tbl[i].cyc);
      finish_op();
    end

    // MTHI immediately followed by MULT 0*0.
    issue("mthi_then_mult: mthi", 3'd4, 32'h12345678, 32'd0, 32'h12345678, 32'h00000000, 0);
    finish_op();
    issue("mthi_then_mult: mult", 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5);
    finish_op();

    // MTLO pulsed at busy cycle 2 must be ignored; 3 busy cycles remain after the pulse.
    issue("multu_mtlo", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 3);
    @(negedge clk);
    Start = 1'b1;
    Op    = 3'd5;
    A     = 32'd5;
    @(negedge clk);
    Start = 1'b0;
    finish_op();

    // Reset at busy cycle 4 of a divide aborts with no later write.
    Start = 1'b1;
    Op    = 3'd2;
    A     = 32'd100;
    B     = 32'd7;
    @(negedge clk);
    Start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort Busy", {31'd0, Busy}, 32'd0);
    check("abort HI", HI, 32'd0);
    check("abort LO", LO, 32'd0);
    repeat (12) @(negedge clk);
    check("abort late Busy", {31'd0, Busy}, 32'd0);
    check("abort late HI", HI, 32'd0);
    check("abort late LO", LO, 32'd0);

    // Reset wins over an MTHI Start on the same edge.
    reset = 1'b1;
    Start = 1'b1;
    Op    = 3'd4;
    A     = 32'hDEADBEEF;
    @(negedge clk);
    reset = 1'b0;
    Start = 1'b0;
    check("reset_vs_start HI", HI, 32'd0);
    check("reset_vs_start Busy", {31'd0, Busy}, 32'd0);

    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard leftover: got %0d entries, expected 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
